// File: rtl/uart_cmd_responder.sv
// rtl/uart_cmd_responder.sv - UART register-access command responder
// Parses raw W/R byte commands from uart_rx, owns an 8-bit register file, replies through uart_tx.
module uart_cmd_responder #(
  parameter int NUM_REGS       = 8,
  parameter int TIMEOUT_CYCLES = 500_000,
  parameter int TO_W           = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  input  logic                  framing_error,
  input  logic                  tx_ready,
  input  logic                  tx_accept,
  output logic                  tx_start,
  output logic [7:0]            tx_byte,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  busy,
  output logic                  overrun
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [7:0]      CMD_WRITE = 8'h57;
  localparam logic [7:0]      CMD_READ  = 8'h52;
  localparam logic [7:0]      RSP_OK    = 8'h4B;
  localparam logic [7:0]      RSP_BAD   = 8'h3F;
  localparam logic [7:0]      RSP_FRAME = 8'h21;
  localparam logic [8:0]      NUM_REGS_W = 9'(NUM_REGS);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_SEND,
    S_WAIT_ACC
  } state_t;

  state_t                     state_q, state_d;
  logic                       is_write_q, is_write_d;
  logic [AW-1:0]              addr_q, addr_d;
  logic [7:0]                 tx_byte_q, tx_byte_d;
  logic                       tx_start_q, tx_start_d;
  logic                       overrun_q, overrun_d;
  logic [TO_W-1:0]            to_cnt_q, to_cnt_d;
  logic [NUM_REGS-1:0][7:0]   regs_q, regs_d;

  logic                       reply_load;
  logic [7:0]                 reply_val;
  logic                       addr_ok;

  assign addr_ok = ({1'b0, rx_byte} < NUM_REGS_W);

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    tx_byte_d  = tx_byte_q;
    tx_start_d = tx_start_q;
    overrun_d  = overrun_q;
    to_cnt_d   = '0;
    regs_d     = regs_q;
    reply_load = 1'b0;
    reply_val  = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (framing_error) begin
          reply_load = 1'b1;
          reply_val  = RSP_FRAME;
        end else if (rx_valid) begin
          if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
            is_write_d = (rx_byte == CMD_WRITE);
            state_d    = S_GET_ADDR;
          end else begin
            reply_load = 1'b1;
            reply_val  = RSP_BAD;
          end
        end
      end

      S_GET_ADDR: begin
        if (framing_error) begin
          reply_load = 1'b1;
          reply_val  = RSP_FRAME;
        end else if (rx_valid) begin
          addr_d = rx_byte[AW-1:0];
          if (!addr_ok) begin
            reply_load = 1'b1;
            reply_val  = RSP_BAD;
          end else if (!is_write_q) begin
            reply_load = 1'b1;
            reply_val  = regs_q[rx_byte[AW-1:0]];
          end else begin
            state_d = S_GET_DATA;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      S_GET_DATA: begin
        if (framing_error) begin
          reply_load = 1'b1;
          reply_val  = RSP_FRAME;
        end else if (rx_valid) begin
          regs_d[addr_q] = rx_byte;
          reply_load     = 1'b1;
          reply_val      = RSP_OK;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      S_SEND: begin
        if (rx_valid) begin
          overrun_d = 1'b1;
        end
        if (tx_ready) begin
          tx_start_d = 1'b1;
          state_d    = S_WAIT_ACC;
        end
      end

      S_WAIT_ACC: begin
        if (rx_valid) begin
          overrun_d = 1'b1;
        end
        if (tx_accept) begin
          tx_start_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        tx_start_d = 1'b0;
      end
    endcase

    // A ready transmitter takes the reply straight away, saving the SEND cycle.
    if (reply_load) begin
      tx_byte_d = reply_val;
      if (tx_ready) begin
        tx_start_d = 1'b1;
        state_d    = S_WAIT_ACC;
      end else begin
        state_d = S_SEND;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      tx_byte_q  <= 8'h00;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
      to_cnt_q   <= '0;
      regs_q     <= '0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      tx_byte_q  <= tx_byte_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
      to_cnt_q   <= to_cnt_d;
      regs_q     <= regs_d;
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_byte   = tx_byte_q;
  assign regs_flat = regs_q;
  assign busy      = (state_q != S_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb/tb_uart_cmd_responder.sv - randomized self-checking bench for uart_cmd_responder
// Commands are generated at transaction level; replies and register contents come from a byte-array model.
module tb_uart_cmd_responder;

  localparam int NR = 8;
  localparam int TO = 40;
  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic          framing_error;
  logic          tx_ready;
  logic          tx_accept;
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic [NR*8-1:0] regs_flat;
  logic          busy;
  logic          overrun;

  uart_cmd_responder #(
    .NUM_REGS      (NR),
    .TIMEOUT_CYCLES(TO),
    .TO_W          (TW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .framing_error(framing_error),
    .tx_ready     (tx_ready),
    .tx_accept    (tx_accept),
    .tx_start     (tx_start),
    .tx_byte      (tx_byte),
    .regs_flat    (regs_flat),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  int   rises = 0;
  int   exp_rises = 0;
  logic prev_start = 1'b0;

  logic [7:0] mdl_regs [NR];
  logic       mdl_ovr;

  always @(negedge clk) begin
    if (tx_start && !prev_start) rises++;
    prev_start = tx_start;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mdl_flat();
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) f[8*i +: 8] = mdl_regs[i];
    return f;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) mdl_regs[i] = 8'h00;
    mdl_ovr = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_fe(input int gap, input bit with_byte);
    repeat (gap) @(negedge clk);
    framing_error = 1'b1;
    rx_valid      = with_byte;
    rx_byte       = 8'($urandom);
    @(negedge clk);
    framing_error = 1'b0;
    rx_valid      = 1'b0;
  endtask

  task automatic get_reply(input logic [7:0] exp, input int hold_low, input int acc_delay,
                           input bit inject, input bit inject_acc);
    exp_rises++;
    if (hold_low > 0) begin
      repeat (hold_low) begin
        chk("start_held_off", {63'b0, tx_start}, 64'd0);
        @(negedge clk);
      end
      tx_ready = 1'b1;
      @(negedge clk);
    end
    chk("start_latency", {63'b0, tx_start}, 64'd1);
    chk("reply_byte", {56'b0, tx_byte}, {56'b0, exp});
    chk("busy_sending", {63'b0, busy}, 64'd1);
    repeat (acc_delay) @(negedge clk);
    if (inject) begin
      rx_valid = 1'b1;
      rx_byte  = 8'h55;
      mdl_ovr  = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      chk("start_hold", {63'b0, tx_start}, 64'd1);
      chk("byte_hold", {56'b0, tx_byte}, {56'b0, exp});
    end
    tx_accept = 1'b1;
    if (inject_acc) begin
      rx_valid = 1'b1;
      rx_byte  = 8'h55;
      mdl_ovr  = 1'b1;
    end
    @(negedge clk);
    tx_accept = 1'b0;
    rx_valid  = 1'b0;
    chk("start_drop", {63'b0, tx_start}, 64'd0);
    chk("busy_idle", {63'b0, busy}, 64'd0);
    chk("overrun", {63'b0, overrun}, {63'b0, mdl_ovr});
  endtask

  task automatic run_cmd(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                         input int fe_pos, input int hold_low, input int acc_delay,
                         input bit inject, input bit inject_acc);
    logic [7:0] b [3];
    logic [7:0] exp;
    int         len;
    bit         fe;
    bit         wr;
    b[0] = cmd;
    b[1] = addr;
    b[2] = data;
    wr   = 1'b0;
    if (cmd != 8'h57 && cmd != 8'h52) begin
      len = 1; exp = 8'h3F;
    end else if (addr >= NR) begin
      len = 2; exp = 8'h3F;
    end else if (cmd == 8'h52) begin
      len = 2; exp = mdl_regs[addr];
    end else begin
      len = 3; exp = 8'h4B; wr = 1'b1;
    end
    fe = (fe_pos > 0 && fe_pos < len);
    if (fe) begin
      len = fe_pos; exp = 8'h21; wr = 1'b0;
    end
    if (hold_low > 0) tx_ready = 1'b0;
    for (int i = 0; i < len; i++) send_byte(b[i], $urandom_range(0, 5));
    if (fe) send_fe($urandom_range(0, 5), 1'($urandom));
    if (wr) begin
      mdl_regs[addr] = data;
      chk("write_visible", regs_flat, mdl_flat());
    end
    get_reply(exp, hold_low, acc_delay, inject, inject_acc);
    chk("regs", regs_flat, mdl_flat());
  endtask

  initial begin
    logic [7:0] c;
    int         r;
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; framing_error = 1'b0;
    tx_ready = 1'b1; tx_accept = 1'b0; mdl_ovr = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    chk("rst_tx_start", {63'b0, tx_start}, 64'd0);
    chk("rst_tx_byte", {56'b0, tx_byte}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_overrun", {63'b0, overrun}, 64'd0);
    chk("rst_regs", regs_flat, 64'd0);

    run_cmd(8'h57, 8'h03, 8'hA5, 0, 0, 2, 0, 0);
    run_cmd(8'h52, 8'h03, 8'h00, 0, 0, 1, 0, 0);
    run_cmd(8'h41, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    run_cmd(8'h57, 8'h08, 8'h00, 0, 0, 0, 0, 0);
    run_cmd(8'h52, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    run_cmd(8'h57, 8'h01, 8'h77, 1, 0, 0, 0, 0);
    run_cmd(8'h57, 8'h01, 8'h77, 2, 0, 1, 0, 0);

    send_byte(8'h52, 0);
    chk("busy_in_cmd", {63'b0, busy}, 64'd1);
    repeat (TO + 5) @(negedge clk);
    chk("timeout_busy", {63'b0, busy}, 64'd0);
    chk("timeout_silent", 64'(rises), 64'(exp_rises));
    run_cmd(8'h52, 8'h01, 8'h00, 0, 0, 0, 0, 0);

    run_cmd(8'h52, 8'h03, 8'h00, 0, 4, 3, 1, 0);
    run_cmd(8'h57, 8'h05, 8'h3C, 0, 2, 0, 0, 1);

    send_byte(8'h57, 0);
    send_byte(8'h02, 1);
    do_reset();
    chk("midrst_tx_byte", {56'b0, tx_byte}, 64'd0);
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    run_cmd(8'hFF, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    chk("midrst_reg2", {56'b0, regs_flat[23:16]}, 64'd0);

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) c = 8'h57;
      else if (r < 8) c = 8'h52;
      else c = 8'($urandom);
      run_cmd(c, 8'($urandom_range(0, NR)), 8'($urandom),
              ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0,
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
              $urandom_range(0, 3),
              ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 4) == 0));
    end

    repeat (3) @(negedge clk);
    chk("reply_count", 64'(rises), 64'(exp_rises));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
